// File: rtl/operand_pkg.sv
// rtl/operand_pkg.sv - shared types and constants for the operand fetch stage
package operand_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int NREG_DEF   = 8;
  localparam int RSEL_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    VALID  = 2'd3
  } state_e;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

endpackage

// File: rtl/operand_fetch_stage_regfile.sv
// rtl/operand_fetch_stage_regfile.sv - NREG x DATA_W register file, 1 write / 2 combinational reads
module regfile
  import operand_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int RSEL_W = RSEL_W_DEF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              we_i,
  input  logic [RSEL_W-1:0] wsel_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [RSEL_W-1:0] rsel_a_i,
  input  logic [RSEL_W-1:0] rsel_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] regs_q [NREG];

  // Storage: reset clears every entry; reset also wins over a pending write.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[wsel_i] <= wdata_i;
    end
  end

  // Reads see pre-edge contents, so a same-cycle write is not bypassed.
  assign rdata_a_o = regs_q[rsel_a_i];
  assign rdata_b_o = regs_q[rsel_b_i];

endmodule

// File: rtl/operand_fetch_stage.sv
// rtl/operand_fetch_stage.sv - sequences A/B operand fetch from the register file for the ALU
module operand_fetch_stage
  import operand_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int RSEL_W = RSEL_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [RSEL_W-1:0] rn_a,
  input  logic [RSEL_W-1:0] rn_b,
  input  logic [1:0]        shift,
  input  logic              asel,
  input  logic              bsel,
  input  logic [4:0]        imm5,
  input  logic              write,
  input  logic [RSEL_W-1:0] writenum,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] Ain,
  output logic [DATA_W-1:0] Bin,
  output logic              valid,
  output logic              busy
);

  state_e              state_q, state_d;
  logic                latch_en;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [RSEL_W-1:0]   rn_a_q, rn_b_q;
  logic [1:0]          shift_q;
  logic                asel_q, bsel_q;
  logic [4:0]          imm5_q;
  logic [DATA_W-1:0]   rd_a, rd_b;
  logic [DATA_W-1:0]   b_shifted;

  regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .RSEL_W (RSEL_W)
  ) u_regfile (
    .clk_i     (clk),
    .reset_i   (reset),
    .we_i      (write),
    .wsel_i    (writenum),
    .wdata_i   (data_in),
    .rsel_a_i  (rn_a_q),
    .rsel_b_i  (rn_b_q),
    .rdata_a_o (rd_a),
    .rdata_b_o (rd_b)
  );

  // Next-state: a start is only honoured when no fetch is in flight.
  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    unique case (state_q)
      IDLE, VALID: begin
        if (start) begin
          state_d  = LOAD_A;
          latch_en = 1'b1;
        end
      end
      LOAD_A:  state_d = LOAD_B;
      LOAD_B:  state_d = VALID;
      default: state_d = IDLE;
    endcase
  end

  // State, latched request fields and operand registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rn_a_q  <= '0;
      rn_b_q  <= '0;
      shift_q <= SH_NONE;
      asel_q  <= 1'b0;
      bsel_q  <= 1'b0;
      imm5_q  <= '0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        rn_a_q  <= rn_a;
        rn_b_q  <= rn_b;
        shift_q <= shift;
        asel_q  <= asel;
        bsel_q  <= bsel;
        imm5_q  <= imm5;
      end
      if (state_q == LOAD_A) a_q <= rd_a;
      if (state_q == LOAD_B) b_q <= rd_b;
    end
  end

  // Shifter and source muxes, driven only from registered state so outputs hold steady in VALID.
  always_comb begin
    b_shifted = b_q;
    unique case (shift_q)
      SH_LSL:  b_shifted = {b_q[DATA_W-2:0], 1'b0};
      SH_LSR:  b_shifted = {1'b0, b_q[DATA_W-1:1]};
      SH_ASR:  b_shifted = {b_q[DATA_W-1], b_q[DATA_W-1:1]};
      default: b_shifted = b_q;
    endcase
  end

  assign Ain   = asel_q ? '0 : a_q;
  assign Bin   = bsel_q ? {{(DATA_W-5){1'b0}}, imm5_q} : b_shifted;
  assign busy  = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign valid = (state_q == VALID);

endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb/tb_operand_fetch_stage.sv - self-checking bench for operand_fetch_stage
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  rn_a = '0, rn_b = '0;
  logic [1:0]  shift = '0;
  logic        asel = 1'b0, bsel = 1'b0;
  logic [4:0]  imm5 = '0;
  logic        write = 1'b0;
  logic [2:0]  writenum = '0;
  logic [15:0] data_in = '0;
  logic [15:0] Ain, Bin;
  logic        valid, busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] mem [8];

  typedef struct {
    logic [2:0]  ra;
    logic [15:0] va;
    logic [2:0]  rb;
    logic [15:0] vb;
    logic [1:0]  sh;
    logic        as;
    logic        bs;
    logic [4:0]  im;
    logic [15:0] ea;
    logic [15:0] eb;
  } vec_t;
  vec_t vecs [6];

  operand_fetch_stage dut (
    .clk(clk), .reset(reset), .start(start), .rn_a(rn_a), .rn_b(rn_b),
    .shift(shift), .asel(asel), .bsel(bsel), .imm5(imm5), .write(write),
    .writenum(writenum), .data_in(data_in), .Ain(Ain), .Bin(Bin),
    .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: inputs applied at negedge, model updated at posedge, back at negedge to sample.
  task automatic step(input logic st, input logic wr, input logic [2:0] wn, input logic [15:0] wd);
    start = st; write = wr; writenum = wn; data_in = wd;
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 8; i++) mem[i] = '0;
    end else if (wr) begin
      mem[wn] = wd;
    end
    @(negedge clk);
    start = 1'b0; write = 1'b0;
  endtask

  function automatic logic [15:0] ref_shift(input logic [15:0] b, input logic [1:0] sh);
    int unsigned v;
    v = b;
    case (sh)
      2'd1:    v = (v * 2) % 65536;
      2'd2:    v = v / 2;
      2'd3:    v = (v / 2) + (v >= 32768 ? 32768 : 0);
      default: v = v;
    endcase
    return 16'(v);
  endfunction

  // Full fetch against the model; optional random writes during the load cycles.
  task automatic do_fetch(input logic [2:0] ra, input logic [2:0] rb, input logic [1:0] sh,
                          input logic as, input logic bs, input logic [4:0] im, input bit randw);
    logic [15:0] ea, eb;
    logic        wr;
    logic [2:0]  wn;
    logic [15:0] wd;
    rn_a = ra; rn_b = rb; shift = sh; asel = as; bsel = bs; imm5 = im;
    step(1'b1, 1'b0, 3'd0, 16'd0);
    check("busy_after_E0", 16'(busy), 16'd1);
    rn_a = 3'($urandom_range(0, 7)); rn_b = 3'($urandom_range(0, 7));
    shift = 2'($urandom_range(0, 3)); asel = 1'($urandom_range(0, 1));
    bsel = 1'($urandom_range(0, 1)); imm5 = 5'($urandom_range(0, 31));
    ea = mem[ra];
    wr = randw ? 1'($urandom_range(0, 1)) : 1'b0;
    wn = 3'($urandom_range(0, 7)); wd = 16'($urandom);
    step(1'b0, wr, wn, wd);
    check("busy_after_E1", 16'(busy), 16'd1);
    eb = mem[rb];
    wr = randw ? 1'($urandom_range(0, 1)) : 1'b0;
    wn = 3'($urandom_range(0, 7)); wd = 16'($urandom);
    step(1'b0, wr, wn, wd);
    ea = as ? 16'd0 : ea;
    eb = bs ? {11'd0, im} : ref_shift(eb, sh);
    check("valid_after_E2", 16'(valid), 16'd1);
    check("busy_after_E2", 16'(busy), 16'd0);
    check("Ain_fetch", Ain, ea);
    check("Bin_fetch", Bin, eb);
    step(1'b0, 1'b1, ra, ~mem[ra]);
    check("Ain_stable_valid", Ain, ea);
    check("Bin_stable_valid", Bin, eb);
    check("valid_held", 16'(valid), 16'd1);
  endtask

  initial begin
    vecs[0] = '{3'd3, 16'h0007, 3'd5, 16'h0002, 2'b00, 1'b0, 1'b0, 5'h00, 16'h0007, 16'h0002};
    vecs[1] = '{3'd3, 16'h0007, 3'd5, 16'h8001, 2'b01, 1'b0, 1'b0, 5'h00, 16'h0007, 16'h0002};
    vecs[2] = '{3'd3, 16'h0007, 3'd5, 16'h8001, 2'b10, 1'b0, 1'b0, 5'h00, 16'h0007, 16'h4000};
    vecs[3] = '{3'd3, 16'h0007, 3'd5, 16'h8001, 2'b11, 1'b0, 1'b0, 5'h00, 16'h0007, 16'hC000};
    vecs[4] = '{3'd3, 16'h1234, 3'd5, 16'h8001, 2'b00, 1'b1, 1'b1, 5'h15, 16'h0000, 16'h0015};
    vecs[5] = '{3'd0, 16'hFFFF, 3'd7, 16'h7FFF, 2'b11, 1'b0, 1'b0, 5'h00, 16'hFFFF, 16'h3FFF};
    for (int i = 0; i < 8; i++) mem[i] = '0;

    @(negedge clk);
    step(1'b0, 1'b0, 3'd0, 16'd0);
    step(1'b0, 1'b0, 3'd0, 16'd0);
    reset = 1'b0;
    check("reset_valid", 16'(valid), 16'd0);
    check("reset_busy", 16'(busy), 16'd0);
    check("reset_Ain", Ain, 16'd0);
    check("reset_Bin", Bin, 16'd0);

    do_fetch(3'd0, 3'd0, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0);

    // Table vectors.
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, vecs[i].ra, vecs[i].va);
      step(1'b0, 1'b1, vecs[i].rb, vecs[i].vb);
      do_fetch(vecs[i].ra, vecs[i].rb, vecs[i].sh, vecs[i].as, vecs[i].bs, vecs[i].im, 1'b0);
      step(1'b0, 1'b0, 3'd0, 16'd0);
      check("tbl_Ain", Ain, vecs[i].ea);
      check("tbl_Bin", Bin, vecs[i].eb);
    end

    // Write collision: R3 written on the same edge A loads from it.
    step(1'b0, 1'b1, 3'd3, 16'h0007);
    rn_a = 3'd3; rn_b = 3'd3; shift = 2'b00; asel = 1'b0; bsel = 1'b0;
    step(1'b1, 1'b0, 3'd0, 16'd0);
    step(1'b0, 1'b1, 3'd3, 16'h00AA);
    step(1'b0, 1'b0, 3'd0, 16'd0);
    check("collision_Ain_old", Ain, 16'h0007);
    check("collision_Bin_new", Bin, 16'h00AA);
    rn_a = 3'd3; rn_b = 3'd0;
    step(1'b1, 1'b0, 3'd0, 16'd0);
    step(1'b0, 1'b0, 3'd0, 16'd0);
    step(1'b0, 1'b0, 3'd0, 16'd0);
    check("collision_next_Ain", Ain, 16'h00AA);

    // start held into LOAD_A is ignored: valid still at original E2.
    step(1'b1, 1'b0, 3'd0, 16'd0);
    step(1'b1, 1'b0, 3'd0, 16'd0);
    step(1'b0, 1'b0, 3'd0, 16'd0);
    check("ignore_valid_E2", 16'(valid), 16'd1);
    step(1'b0, 1'b0, 3'd0, 16'd0);
    check("ignore_no_refetch", 16'(valid), 16'd1);
    check("ignore_busy", 16'(busy), 16'd0);

    // Reset in LOAD_B with a pending write to R3.
    rn_a = 3'd3; rn_b = 3'd3;
    step(1'b1, 1'b0, 3'd0, 16'd0);
    step(1'b0, 1'b0, 3'd0, 16'd0);
    check("pre_reset_busy", 16'(busy), 16'd1);
    reset = 1'b1;
    step(1'b0, 1'b1, 3'd3, 16'h0055);
    reset = 1'b0;
    check("midreset_valid", 16'(valid), 16'd0);
    check("midreset_busy", 16'(busy), 16'd0);
    check("midreset_Ain", Ain, 16'd0);
    check("midreset_Bin", Bin, 16'd0);
    do_fetch(3'd3, 3'd3, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0);
    check("R3_after_reset", Ain, 16'd0);

    // Randomized fetches against the model.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        step(1'b0, 1'b1, 3'($urandom_range(0, 7)), 16'($urandom));
      end
      do_fetch(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
